// File: rtl/uart_rx_if.sv
// Byte delivery bundle between the UART receiver and its consumer.
// The receiver drives data, valid and the error pulses; the consumer returns the ack.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun_err,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, glitch/framing/overrun handling.
// Byte shows up on rx_data/rx_valid at the mid-stop-bit edge; it is held until acked, and a newer byte that finds it unacked is dropped.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      busy
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 oerr_q, oerr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      oerr_q  <= oerr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = data_q;
    valid_nxt   = valid_q;
    ferr_nxt    = 1'b0;
    oerr_nxt    = 1'b0;

    // A plain ack drops valid; a delivery in the same cycle overrides this below.
    if (valid_q && bus.rx_ack) valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt != CNT_HALF) begin
          cnt_nxt = cnt + CNT_ONE;
        end else if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = DATA;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (cnt != CNT_FULL) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          shift_nxt   = {rx_s, shift[DATA_BITS-1:1]};
          bit_idx_nxt = bit_idx + IDX_ONE;
          cnt_nxt     = '0;
          if (bit_idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt != CNT_FULL) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          cnt_nxt = '0;
          if (rx_s) begin
            // Leave at mid-stop-bit so an immediately following start edge is caught.
            state_nxt = IDLE;
            if (!valid_q || bus.rx_ack) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end else begin
              oerr_nxt = 1'b1;
            end
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = oerr_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed 8N1 frames into uart_rx at 16 clk/bit; expected bytes are queued at stimulus
// time and a negedge monitor pops and compares on every new delivery.
module tb_uart_rx;
  localparam int C = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic busy;

  uart_rx_if #(.DATA_BITS(8)) bus_if ();

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .bus  (bus_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         oerr_cnt = 0;
  int         last_rise = -1;
  int         last_ferr = -1;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  int         t0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: a delivery is valid rising, or the held byte being replaced.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.rx_valid && (!pv || bus_if.rx_data != pd)) begin
        if (!pv) last_rise = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_delivery: got 0x%0h with nothing expected (cycle %0d)",
                   bus_if.rx_data, cyc);
        end else begin
          check("rx_data", {24'h0, bus_if.rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (bus_if.frame_err) begin
        ferr_cnt++;
        last_ferr = cyc;
      end
      if (bus_if.overrun_err) oerr_cnt++;
    end
    pv = bus_if.rx_valid;
    pd = bus_if.rx_data;
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus_if.rx_ack = 1'b1;
    @(negedge clk);
    bus_if.rx_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.rx_ack = 1'b0;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", {24'h0, bus_if.rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, bus_if.rx_valid}, 32'h0);
    check("reset_frame_err", {31'h0, bus_if.frame_err}, 32'h0);
    check("reset_overrun_err", {31'h0, bus_if.overrun_err}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single byte with latency and hold/ack behaviour
    t0 = cyc + 1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("a5_rise_cycle", last_rise, t0 + 154);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("a5_valid_held", {31'h0, bus_if.rx_valid}, 32'h1);
    bus_if.rx_ack = 1'b1;
    @(negedge clk);
    bus_if.rx_ack = 1'b0;
    check("a5_valid_cleared", {31'h0, bus_if.rx_valid}, 32'h0);
    @(posedge clk);
    #1;

    // Glitch: 5 low cycles
    t0 = cyc + 1;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    while (cyc < t0 + 9) @(negedge clk);
    check("glitch_busy_before", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("glitch_busy_after", {31'h0, busy}, 32'h0);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_no_valid", {31'h0, bus_if.rx_valid}, 32'h0);
    @(posedge clk);
    #1;

    // Framing error followed by a 40-bit break
    t0 = cyc + 1;
    send_frame(8'h3C, 1'b0);
    repeat (40 * C) @(posedge clk);
    #1;
    rx = 1'b1;
    check("break_one_ferr", ferr_cnt, 1);
    check("break_ferr_cycle", last_ferr, t0 + 154);
    check("break_no_valid", {31'h0, bus_if.rx_valid}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    t0 = cyc + 1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check("x55_rise_cycle", last_rise, t0 + 154);
    check("x55_data", {24'h0, bus_if.rx_data}, 32'h55);
    ack_pulse();

    // Back-to-back with ack in the completion cycle of the second byte
    t0 = cyc + 1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    fork
      begin
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
      end
      begin
        while (cyc < t0 + 160 + 153) @(negedge clk);
        bus_if.rx_ack = 1'b1;
        @(negedge clk);
        bus_if.rx_ack = 1'b0;
      end
    join
    @(negedge clk);
    check("b2b_valid", {31'h0, bus_if.rx_valid}, 32'h1);
    check("b2b_data", {24'h0, bus_if.rx_data}, 32'h02);
    check("b2b_no_overrun", oerr_cnt, 0);
    check("b2b_first_rise", last_rise, t0 + 154);
    ack_pulse();

    // Overrun: second byte finds the first unacked
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    check("ovr_count", oerr_cnt, 1);
    check("ovr_data_kept", {24'h0, bus_if.rx_data}, 32'h11);
    check("ovr_valid", {31'h0, bus_if.rx_valid}, 32'h1);
    @(posedge clk);
    #1;

    // Reset during the data bits of 0x33
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = (8'h33 >> i) & 8'h01;
      repeat (C) @(posedge clk);
      #1;
    end
    check("midframe_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'h0, bus_if.rx_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("rst_no_delivery", {31'h0, bus_if.rx_valid}, 32'h0);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_ferr_total", ferr_cnt, 1);
    check("final_oerr_total", oerr_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the RISC-V core's serial port: 8N1 frames on the `rx` pin, delivered as bytes over a valid/ack handshake.
- Sits inside risc_v_top between the `rx` input pad and the core's UART register block.
- It is the receive-direction partner of the core's serial transmitter.
- Handles input synchronisation, mid-bit sampling, glitch rejection, framing errors and overrun.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be >= 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  core clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line from the pad; idle high.
- rx_ack  input  1  consumer accepts rx_data; sampled only while rx_valid=1.
- rx_data  output  DATA_BITS  last received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until acknowledged.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: byte completed while the previous one was unacknowledged.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Reset:
- rst_n=0 at a clock edge forces: state=IDLE, both sync flops=1, counters=0, shift register=0.
- Output reset values: rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
- Reset mid-frame aborts the frame; no partial byte is ever delivered.

Synchroniser:
- Two flops; rx_s is the second stage.
- The FSM uses only rx_s.

Timing constants:
- H = CLKS_PER_BIT/2 (integer division), C = CLKS_PER_BIT.
- cnt is a bit-period counter with width clog2(C).
- bit_idx has width clog2(DATA_BITS+1).

FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rx_s=0 -> START with cnt=0.
- START: while cnt!=H-1, cnt++. At cnt==H-1, sample rx_s:
  - 1 -> IDLE (glitch rejected, no error flag).
  - 0 -> DATA with cnt=0, bit_idx=0.
- DATA: while cnt!=C-1, cnt++. At cnt==C-1:
  - Shift rx_s in at the MSB (right shift), so the LSB-first stream lands correctly; bit_idx++, cnt=0.
  - After the DATA_BITS-th sample -> STOP.
- STOP: while cnt!=C-1, cnt++. At cnt==C-1, sample rx_s:
  - 1 -> delivery rules (below), then IDLE. The FSM returns to IDLE at mid-stop-bit so back-to-back frames are caught.
  - 0 -> frame_err=1 for one cycle, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s=1, then IDLE. A break (line held low) therefore yields exactly one frame_err.

Delivery rules (on a good stop bit):
- rx_valid=0: rx_data<=shift, rx_valid<=1.
- rx_valid=1 and rx_ack=1 in the same cycle: rx_data<=new byte, rx_valid stays 1, no overrun.
- rx_valid=1 and rx_ack=0: new byte discarded, old rx_data kept, overrun_err=1 for one cycle.

Handshake:
- rx_valid=1 and rx_ack=1 with no completion that cycle -> rx_valid<=0 on that edge.
- rx_ack while rx_valid=0 is ignored.

Latency:
- Let T0 be the first rising edge at which the rx pin is sampled 0.
- FSM enters START at edge T0+2.
- Data bit i is sampled at edge T0+2+H+(i+1)*C.
- Stop bit is sampled, and rx_valid/frame_err update, at edge T0+2+H+(DATA_BITS+1)*C. Timing is exact with no jitter allowance.

Test Plan:
- Reset check: CLKS_PER_BIT=16. Hold rst_n=0 for 3 cycles with rx=1 -> all outputs 0, busy=0.
- Single byte: drive 0xA5 as 8N1 (16 clk/bit) -> rx_valid rises at T0+154 with rx_data=0xA5. Hold rx_ack=0 -> rx_valid stays 1; pulse rx_ack -> rx_valid=0 next edge.
- Glitch rejection: rx low for 5 cycles, then high -> busy returns to 0 at T0+10, no rx_valid, no frame_err.
- Framing error / break: send 0x3C with the stop bit low, then hold rx low for 40 bit-times -> exactly one frame_err pulse at T0+154, rx_valid stays 0. Raise rx, then send 0x55 -> rx_data=0x55 delivered.
- Back-to-back with ack: 0x01 then 0x02 with zero idle time, rx_ack asserted in the cycle the second byte completes -> rx_valid stays 1, rx_data=0x02, no overrun_err.
- Overrun and mid-frame reset:
  - 0x11 unacked, then 0x22 -> overrun_err pulse, rx_data remains 0x11.
  - Then assert rst_n=0 during the data bits of 0x33 -> rx_valid=0, no byte delivered afterwards.
